// File: rtl/dcache_tbus_arb_pkg.sv
// Shared definitions for the dcache trinity-bus arbiter: operation encodings,
// request ownership and the arbiter FSM states.
package dcache_tbus_arb_pkg;

    localparam int TBUS_OPTYPE_W = 2;

    localparam logic [TBUS_OPTYPE_W-1:0] TBUS_READ  = 2'b00;
    localparam logic [TBUS_OPTYPE_W-1:0] TBUS_WRITE = 2'b01;

    // Which requester currently owns the single in-flight transaction
    typedef enum logic [1:0] {
        NONE = 2'd0,
        LD   = 2'd1,
        ST   = 2'd2
    } owner_e;

    // IDLE picks a winner, REQ presents it to the dcache, WAIT holds until completion
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/dcache_tbus_arb.sv
// Arbitrates committed stores and loads onto the single dcache tbus request
// channel. One transaction is in flight at a time; loads win unless a store
// has been blocked long enough, and a flush silently kills an owned load.
module dcache_tbus_arb
    import dcache_tbus_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     sq2arb_tbus_index_valid,
    output logic                     sq2arb_tbus_index_ready,
    input  logic [63:0]              sq2arb_tbus_index,
    input  logic [63:0]              sq2arb_tbus_write_data,
    input  logic [63:0]              sq2arb_tbus_write_mask,
    output logic                     sq2arb_tbus_operation_done,

    input  logic                     ldu2arb_tbus_index_valid,
    output logic                     ldu2arb_tbus_index_ready,
    input  logic [63:0]              ldu2arb_tbus_index,
    output logic [63:0]              ldu2arb_tbus_read_data,
    output logic                     ldu2arb_tbus_operation_done,

    input  logic                     flush_valid,

    output logic                     arb2dc_tbus_index_valid,
    input  logic                     arb2dc_tbus_index_ready,
    output logic [63:0]              arb2dc_tbus_index,
    output logic [63:0]              arb2dc_tbus_write_data,
    output logic [63:0]              arb2dc_tbus_write_mask,
    output logic [TBUS_OPTYPE_W-1:0] arb2dc_tbus_operation_type,
    input  logic [63:0]              arb2dc_tbus_read_data,
    input  logic                     arb2dc_tbus_operation_done
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_e           state_q,     state_d;
    owner_e           owner_q,     owner_d;
    logic [CNT_W-1:0] starveCnt_q, starveCnt_d;
    logic             kill_q,      kill_d;

    logic storeGrant;
    logic loadFlushed;
    logic doneFire;

    // A flush this cycle affects only a load that the arbiter currently owns
    assign loadFlushed = flush_valid && (owner_q == LD);
    assign doneFire    = (state_q == WAIT) && arb2dc_tbus_operation_done;

    // State, owner, starvation counter and kill flag registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= NONE;
            starveCnt_q <= '0;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starveCnt_q <= starveCnt_d;
            kill_q      <= kill_d;
        end
    end

    // Next-state logic: grant selection, request handshake, completion and flush handling
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        kill_d      = kill_q;
        starveCnt_d = starveCnt_q;
        storeGrant  = 1'b0;

        case (state_q)
            IDLE: begin
                kill_d = 1'b0;
                if (sq2arb_tbus_index_valid && (starveCnt_q == LIMIT)) begin
                    owner_d    = ST;
                    state_d    = REQ;
                    storeGrant = 1'b1;
                end else if (ldu2arb_tbus_index_valid && !flush_valid) begin
                    owner_d = LD;
                    state_d = REQ;
                end else if (sq2arb_tbus_index_valid) begin
                    owner_d    = ST;
                    state_d    = REQ;
                    storeGrant = 1'b1;
                end
            end
            REQ: begin
                if (loadFlushed) begin
                    if (arb2dc_tbus_index_ready) begin
                        state_d = WAIT;
                        kill_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        owner_d = NONE;
                    end
                end else if (arb2dc_tbus_index_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (arb2dc_tbus_operation_done) begin
                    state_d = IDLE;
                    owner_d = NONE;
                    kill_d  = 1'b0;
                end else if (loadFlushed) begin
                    kill_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = NONE;
                kill_d  = 1'b0;
            end
        endcase

        if (storeGrant) begin
            starveCnt_d = '0;
        end else if (sq2arb_tbus_index_valid && (owner_q != ST) && (starveCnt_q != LIMIT)) begin
            starveCnt_d = starveCnt_q + 1'b1;
        end
    end

    // Output muxing: present the owner's live payload in REQ and route completion back
    always_comb begin
        arb2dc_tbus_index_valid     = 1'b0;
        arb2dc_tbus_index           = '0;
        arb2dc_tbus_write_data      = '0;
        arb2dc_tbus_write_mask      = '0;
        arb2dc_tbus_operation_type  = TBUS_READ;
        sq2arb_tbus_index_ready     = 1'b0;
        ldu2arb_tbus_index_ready    = 1'b0;
        sq2arb_tbus_operation_done  = 1'b0;
        ldu2arb_tbus_operation_done = 1'b0;
        ldu2arb_tbus_read_data      = '0;

        if (state_q == REQ) begin
            arb2dc_tbus_index_valid = 1'b1;
            if (owner_q == ST) begin
                arb2dc_tbus_index          = sq2arb_tbus_index;
                arb2dc_tbus_write_data     = sq2arb_tbus_write_data;
                arb2dc_tbus_write_mask     = sq2arb_tbus_write_mask;
                arb2dc_tbus_operation_type = TBUS_WRITE;
                sq2arb_tbus_index_ready    = arb2dc_tbus_index_ready;
            end else if (owner_q == LD) begin
                arb2dc_tbus_index          = ldu2arb_tbus_index;
                ldu2arb_tbus_index_ready   = arb2dc_tbus_index_ready;
            end
        end

        if (doneFire && (owner_q == ST)) begin
            sq2arb_tbus_operation_done = 1'b1;
        end

        if (doneFire && (owner_q == LD) && !kill_q && !flush_valid) begin
            ldu2arb_tbus_operation_done = 1'b1;
            ldu2arb_tbus_read_data      = arb2dc_tbus_read_data;
        end
    end

    // Completion pulses are only legal while a transaction is outstanding
    doneOnlyInWait: assert property (@(posedge clock) disable iff (reset)
        arb2dc_tbus_operation_done |-> (state_q == WAIT));

    // A store request must stay up with a stable payload until it is accepted
    storeHeld: assert property (@(posedge clock) disable iff (reset)
        (sq2arb_tbus_index_valid && !sq2arb_tbus_index_ready) |=>
        (sq2arb_tbus_index_valid && $stable(sq2arb_tbus_index)));

    // A load request must stay up until accepted, unless a flush redirects the load unit
    loadHeld: assert property (@(posedge clock) disable iff (reset)
        (ldu2arb_tbus_index_valid && !ldu2arb_tbus_index_ready && !flush_valid) |=>
        (ldu2arb_tbus_index_valid && $stable(ldu2arb_tbus_index)));

endmodule

// File: tb/tb_dcache_tbus_arb.sv
// Directed scoreboard bench for dcache_tbus_arb: requester drivers feed the
// arbiter, a small dcache responder answers, and a monitor matches every
// handshake and completion against hand-computed expected events.
module tb_dcache_tbus_arb;

    localparam logic [1:0]  OP_READ  = 2'b00;
    localparam logic [1:0]  OP_WRITE = 2'b01;
    localparam logic [63:0] RD_KEY   = 64'h5A5A_1234_0000_A5A5;

    localparam int EV_REQ    = 0;
    localparam int EV_SQDONE = 1;
    localparam int EV_LDDONE = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;

    logic        sq2arb_tbus_index_valid = 1'b0;
    logic        sq2arb_tbus_index_ready;
    logic [63:0] sq2arb_tbus_index = '0;
    logic [63:0] sq2arb_tbus_write_data = '0;
    logic [63:0] sq2arb_tbus_write_mask = '0;
    logic        sq2arb_tbus_operation_done;

    logic        ldu2arb_tbus_index_valid = 1'b0;
    logic        ldu2arb_tbus_index_ready;
    logic [63:0] ldu2arb_tbus_index = '0;
    logic [63:0] ldu2arb_tbus_read_data;
    logic        ldu2arb_tbus_operation_done;

    logic        flush_valid = 1'b0;

    logic        arb2dc_tbus_index_valid;
    logic        arb2dc_tbus_index_ready = 1'b0;
    logic [63:0] arb2dc_tbus_index;
    logic [63:0] arb2dc_tbus_write_data;
    logic [63:0] arb2dc_tbus_write_mask;
    logic [1:0]  arb2dc_tbus_operation_type;
    logic [63:0] arb2dc_tbus_read_data;
    logic        arb2dc_tbus_operation_done;

    logic        respDone = 1'b0;
    logic        manualDone = 1'b0;
    logic [63:0] respData = '0;
    logic        respEn = 1'b1;
    int          doneLat = 1;
    logic        fixedEn = 1'b0;
    logic [63:0] fixedData = '0;
    logic [63:0] respIdx;

    assign arb2dc_tbus_operation_done = respDone | manualDone;
    assign arb2dc_tbus_read_data      = respData;

    typedef struct {
        int          kind;
        int          cycle;
        logic        isStore;
        logic [63:0] idx;
        logic [63:0] wdata;
        logic [63:0] mask;
        logic [1:0]  op;
        logic [63:0] rdata;
    } ev_t;

    typedef struct {
        logic [63:0] idx;
        logic [63:0] wdata;
        logic [63:0] mask;
    } st_t;

    ev_t         expQ[$];
    st_t         sqQ[$];
    logic [63:0] ldQ[$];
    st_t         sqCur;

    int  nPass = 0;
    int  nChecks = 0;
    int  cyc = 0;
    int  c0;
    logic sqHs;
    logic ldDrop;

    dcache_tbus_arb #(
        .STARVE_LIMIT(8),
        .CNT_W(4)
    ) dut (
        .clock                       (clock),
        .reset                       (reset),
        .sq2arb_tbus_index_valid     (sq2arb_tbus_index_valid),
        .sq2arb_tbus_index_ready     (sq2arb_tbus_index_ready),
        .sq2arb_tbus_index           (sq2arb_tbus_index),
        .sq2arb_tbus_write_data      (sq2arb_tbus_write_data),
        .sq2arb_tbus_write_mask      (sq2arb_tbus_write_mask),
        .sq2arb_tbus_operation_done  (sq2arb_tbus_operation_done),
        .ldu2arb_tbus_index_valid    (ldu2arb_tbus_index_valid),
        .ldu2arb_tbus_index_ready    (ldu2arb_tbus_index_ready),
        .ldu2arb_tbus_index          (ldu2arb_tbus_index),
        .ldu2arb_tbus_read_data      (ldu2arb_tbus_read_data),
        .ldu2arb_tbus_operation_done (ldu2arb_tbus_operation_done),
        .flush_valid                 (flush_valid),
        .arb2dc_tbus_index_valid     (arb2dc_tbus_index_valid),
        .arb2dc_tbus_index_ready     (arb2dc_tbus_index_ready),
        .arb2dc_tbus_index           (arb2dc_tbus_index),
        .arb2dc_tbus_write_data      (arb2dc_tbus_write_data),
        .arb2dc_tbus_write_mask      (arb2dc_tbus_write_mask),
        .arb2dc_tbus_operation_type  (arb2dc_tbus_operation_type),
        .arb2dc_tbus_read_data       (arb2dc_tbus_read_data),
        .arb2dc_tbus_operation_done  (arb2dc_tbus_operation_done)
    );

    // Free-running clock and cycle index used to stamp expected events
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    endtask

    task automatic expectReq(input int cycle, input logic isStore, input logic [63:0] idx,
                             input logic [63:0] wdata, input logic [63:0] mask);
        ev_t e;
        e.kind = EV_REQ; e.cycle = cycle; e.isStore = isStore; e.idx = idx;
        e.wdata = isStore ? wdata : 64'd0;
        e.mask  = isStore ? mask  : 64'd0;
        e.op    = isStore ? OP_WRITE : OP_READ;
        e.rdata = '0;
        expQ.push_back(e);
    endtask

    task automatic expectDone(input int cycle, input int kind, input logic [63:0] rdata);
        ev_t e;
        e.kind = kind; e.cycle = cycle; e.isStore = (kind == EV_SQDONE);
        e.idx = '0; e.wdata = '0; e.mask = '0; e.op = OP_READ; e.rdata = rdata;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic isStore, input logic [63:0] idx,
                                 input logic [63:0] wdata, input logic [63:0] mask);
        st_t s;
        if (isStore) begin
            s.idx = idx; s.wdata = wdata; s.mask = mask;
            sqQ.push_back(s);
        end else begin
            ldQ.push_back(idx);
        end
    endtask

    task automatic handleEvent(input int kind);
        ev_t e;
        if (expQ.size() == 0) begin
            checkOutput("unexpected-event", 64'(kind), 64'hFFFF_FFFF_FFFF_FFFF);
            return;
        end
        e = expQ.pop_front();
        checkOutput("event-kind", 64'(kind), 64'(e.kind));
        if (kind != e.kind) return;
        checkOutput("event-cycle", 64'(cyc), 64'(e.cycle));
        if (kind == EV_REQ) begin
            checkOutput("req-index", arb2dc_tbus_index, e.idx);
            checkOutput("req-wdata", arb2dc_tbus_write_data, e.wdata);
            checkOutput("req-mask", arb2dc_tbus_write_mask, e.mask);
            checkOutput("req-optype", 64'(arb2dc_tbus_operation_type), 64'(e.op));
            checkOutput("req-sq-ready", 64'(sq2arb_tbus_index_ready), 64'(e.isStore));
            checkOutput("req-ld-ready", 64'(ldu2arb_tbus_index_ready), 64'(!e.isStore));
        end else if (kind == EV_LDDONE) begin
            checkOutput("ld-rdata", ldu2arb_tbus_read_data, e.rdata);
        end
    endtask

    // Monitor: every handshake or completion seen on the DUT pops one expected event
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            if (arb2dc_tbus_index_valid && arb2dc_tbus_index_ready) handleEvent(EV_REQ);
            if (sq2arb_tbus_operation_done) handleEvent(EV_SQDONE);
            if (ldu2arb_tbus_operation_done) handleEvent(EV_LDDONE);
        end
    end

    // Dcache responder: completion doneLat cycles after the accepting cycle
    initial forever begin
        @(negedge clock);
        if (respEn && !reset && arb2dc_tbus_index_valid && arb2dc_tbus_index_ready) begin
            respIdx = arb2dc_tbus_index;
            @(posedge clock); #1;
            repeat (doneLat - 1) begin
                @(posedge clock); #1;
            end
            respDone = 1'b1;
            respData = fixedEn ? fixedData : (respIdx ^ RD_KEY);
            @(posedge clock); #1;
            respDone = 1'b0;
            respData = '0;
        end
    end

    // Store queue driver: holds each store until accepted, then presents the next
    initial forever begin
        @(negedge clock);
        sqHs = sq2arb_tbus_index_valid && sq2arb_tbus_index_ready && !reset;
        @(posedge clock); #2;
        if (sqHs) begin
            sq2arb_tbus_index_valid = 1'b0;
            sq2arb_tbus_index       = '0;
            sq2arb_tbus_write_data  = '0;
            sq2arb_tbus_write_mask  = '0;
        end
        if (!sq2arb_tbus_index_valid && sqQ.size() > 0) begin
            sqCur = sqQ.pop_front();
            sq2arb_tbus_index_valid = 1'b1;
            sq2arb_tbus_index       = sqCur.idx;
            sq2arb_tbus_write_data  = sqCur.wdata;
            sq2arb_tbus_write_mask  = sqCur.mask;
        end
    end

    // Load unit driver: drops a load once accepted or when a flush redirects it
    initial forever begin
        @(negedge clock);
        ldDrop = ldu2arb_tbus_index_valid && (ldu2arb_tbus_index_ready || flush_valid) && !reset;
        @(posedge clock); #2;
        if (ldDrop) begin
            ldu2arb_tbus_index_valid = 1'b0;
            ldu2arb_tbus_index       = '0;
        end
        if (!ldu2arb_tbus_index_valid && ldQ.size() > 0) begin
            ldu2arb_tbus_index_valid = 1'b1;
            ldu2arb_tbus_index       = ldQ.pop_front();
        end
    end

    task automatic nextCycle();
        @(posedge clock); #1;
    endtask

    task automatic waitDrain(input int bound);
        int n = 0;
        while ((expQ.size() != 0 || sqQ.size() != 0 || ldQ.size() != 0) && n < bound) begin
            @(posedge clock);
            n++;
        end
        checkOutput("drain-pending", 64'(expQ.size()), 64'd0);
        expQ.delete();
        repeat (3) nextCycle();
    endtask

    // Absolute time limit so the bench always terminates
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("rst-dc-valid", 64'(arb2dc_tbus_index_valid), 64'd0);
        checkOutput("rst-optype", 64'(arb2dc_tbus_operation_type), 64'(OP_READ));
        checkOutput("rst-index", arb2dc_tbus_index, 64'd0);
        checkOutput("rst-sq-ready", 64'(sq2arb_tbus_index_ready), 64'd0);
        checkOutput("rst-ld-ready", 64'(ldu2arb_tbus_index_ready), 64'd0);
        checkOutput("rst-sq-done", 64'(sq2arb_tbus_operation_done), 64'd0);
        checkOutput("rst-ld-done", 64'(ldu2arb_tbus_operation_done), 64'd0);
        checkOutput("rst-ld-rdata", ldu2arb_tbus_read_data, 64'd0);
        nextCycle();
        reset = 1'b0;
        nextCycle();

        $display("[TB] test 1: store only");
        arb2dc_tbus_index_ready = 1'b1;
        doneLat = 3;
        c0 = cyc;
        applyStimulus(1'b1, 64'h0000_0000_0000_1000, 64'h1111_2222_3333_4444, 64'h0000_0000_FFFF_FFFF);
        expectReq(c0 + 1, 1'b1, 64'h0000_0000_0000_1000, 64'h1111_2222_3333_4444, 64'h0000_0000_FFFF_FFFF);
        expectDone(c0 + 4, EV_SQDONE, 64'd0);
        waitDrain(40);

        $display("[TB] test 2: load and store together");
        doneLat = 1;
        c0 = cyc;
        applyStimulus(1'b0, 64'h0000_0000_0000_2000, 64'd0, 64'd0);
        applyStimulus(1'b1, 64'h0000_0000_0000_2040, 64'hAAAA_BBBB_CCCC_DDDD, 64'hFF00_FF00_FF00_FF00);
        expectReq(c0 + 1, 1'b0, 64'h0000_0000_0000_2000, 64'd0, 64'd0);
        expectDone(c0 + 2, EV_LDDONE, 64'h5A5A_1234_0000_85A5);
        expectReq(c0 + 4, 1'b1, 64'h0000_0000_0000_2040, 64'hAAAA_BBBB_CCCC_DDDD, 64'hFF00_FF00_FF00_FF00);
        expectDone(c0 + 5, EV_SQDONE, 64'd0);
        waitDrain(40);

        $display("[TB] test 3: load stream starves a store");
        c0 = cyc;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 64'h3000 + 64'(i * 8), 64'd0, 64'd0);
        applyStimulus(1'b1, 64'h0000_0000_0000_3800, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF);
        expectReq(c0 + 1, 1'b0, 64'h3000, 64'd0, 64'd0);
        expectDone(c0 + 2, EV_LDDONE, 64'h5A5A_1234_0000_95A5);
        expectReq(c0 + 4, 1'b0, 64'h3008, 64'd0, 64'd0);
        expectDone(c0 + 5, EV_LDDONE, 64'h5A5A_1234_0000_95AD);
        expectReq(c0 + 7, 1'b0, 64'h3010, 64'd0, 64'd0);
        expectDone(c0 + 8, EV_LDDONE, 64'h5A5A_1234_0000_95B5);
        expectReq(c0 + 10, 1'b1, 64'h3800, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF);
        expectDone(c0 + 11, EV_SQDONE, 64'd0);
        expectReq(c0 + 13, 1'b0, 64'h3018, 64'd0, 64'd0);
        expectDone(c0 + 14, EV_LDDONE, 64'h5A5A_1234_0000_95BD);
        expectReq(c0 + 16, 1'b0, 64'h3020, 64'd0, 64'd0);
        expectDone(c0 + 17, EV_LDDONE, 64'h5A5A_1234_0000_9585);
        waitDrain(80);

        $display("[TB] test 4: flush while load waits");
        doneLat = 4;
        fixedEn = 1'b1;
        fixedData = 64'h0000_0000_0000_DEAD;
        c0 = cyc;
        applyStimulus(1'b0, 64'h0000_0000_0000_4000, 64'd0, 64'd0);
        expectReq(c0 + 1, 1'b0, 64'h0000_0000_0000_4000, 64'd0, 64'd0);
        nextCycle();
        nextCycle();
        flush_valid = 1'b1;
        nextCycle();
        flush_valid = 1'b0;
        nextCycle();
        nextCycle();
        applyStimulus(1'b1, 64'h0000_0000_0000_4100, 64'h5555_6666_7777_8888, 64'h00FF_00FF_00FF_00FF);
        expectReq(c0 + 7, 1'b1, 64'h0000_0000_0000_4100, 64'h5555_6666_7777_8888, 64'h00FF_00FF_00FF_00FF);
        expectDone(c0 + 11, EV_SQDONE, 64'd0);
        @(negedge clock);
        checkOutput("flush-ld-done", 64'(ldu2arb_tbus_operation_done), 64'd0);
        checkOutput("flush-ld-rdata", ldu2arb_tbus_read_data, 64'd0);
        waitDrain(40);
        fixedEn = 1'b0;

        $display("[TB] test 5: flush while load stalls in request");
        arb2dc_tbus_index_ready = 1'b0;
        doneLat = 2;
        c0 = cyc;
        applyStimulus(1'b0, 64'h0000_0000_0000_5000, 64'd0, 64'd0);
        applyStimulus(1'b1, 64'h0000_0000_0000_5080, 64'hCAFE_F00D_0000_0001, 64'h0000_0000_0000_00FF);
        expectReq(c0 + 5, 1'b1, 64'h0000_0000_0000_5080, 64'hCAFE_F00D_0000_0001, 64'h0000_0000_0000_00FF);
        expectDone(c0 + 7, EV_SQDONE, 64'd0);
        nextCycle();
        nextCycle();
        nextCycle();
        flush_valid = 1'b1;
        @(negedge clock);
        checkOutput("stall-dc-valid", 64'(arb2dc_tbus_index_valid), 64'd1);
        checkOutput("stall-index", arb2dc_tbus_index, 64'h0000_0000_0000_5000);
        nextCycle();
        flush_valid = 1'b0;
        arb2dc_tbus_index_ready = 1'b1;
        @(negedge clock);
        checkOutput("abort-dc-valid", 64'(arb2dc_tbus_index_valid), 64'd0);
        waitDrain(40);

        $display("[TB] test 6: reset during wait");
        respEn = 1'b0;
        c0 = cyc;
        applyStimulus(1'b1, 64'h0000_0000_0000_6000, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000);
        expectReq(c0 + 1, 1'b1, 64'h0000_0000_0000_6000, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000);
        nextCycle();
        nextCycle();
        nextCycle();
        manualDone = 1'b1;
        reset = 1'b1;
        #1;
        checkOutput("rstwait-sq-done", 64'(sq2arb_tbus_operation_done), 64'd0);
        checkOutput("rstwait-ld-done", 64'(ldu2arb_tbus_operation_done), 64'd0);
        checkOutput("rstwait-dc-valid", 64'(arb2dc_tbus_index_valid), 64'd0);
        checkOutput("rstwait-optype", 64'(arb2dc_tbus_operation_type), 64'(OP_READ));
        checkOutput("rstwait-event-left", 64'(expQ.size()), 64'd0);
        nextCycle();
        nextCycle();
        manualDone = 1'b0;
        nextCycle();
        reset = 1'b0;
        respEn = 1'b1;
        doneLat = 1;
        c0 = cyc;
        applyStimulus(1'b1, 64'h0000_0000_0000_6100, 64'h0F0F_0F0F_0F0F_0F0F, 64'hFFFF_FFFF_0000_0000);
        expectReq(c0 + 1, 1'b1, 64'h0000_0000_0000_6100, 64'h0F0F_0F0F_0F0F_0F0F, 64'hFFFF_FFFF_0000_0000);
        expectDone(c0 + 2, EV_SQDONE, 64'd0);
        waitDrain(40);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
